// File: rtl/key_sw_conditioner_pkg.sv
// Shared constants for the key/switch input-conditioning stage.
package key_sw_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CNT_SIM   = 8;
  localparam int unsigned DEBOUNCE_CNT_BOARD = 1_000_000;
  localparam int unsigned N_KEY              = 4;
  localparam int unsigned N_SW               = 4;

  // Width of a debounce counter that must reach cnt_max-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cnt_max);
    return (cnt_max > 1) ? $clog2(cnt_max) : 1;
  endfunction

endpackage

// File: rtl/key_sw_conditioner_debounce_bit.sv
// One conditioned input bit: 2-FF synchroniser, stability counter and
// registered rise/fall pulses on the accepted level.
module debounce_bit
  import key_sw_conditioner_pkg::*;
#(
  parameter int unsigned CNT_MAX    = DEBOUNCE_CNT_SIM,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  CNT_TOP = CW'(CNT_MAX - 1);

  logic          s1;
  logic          s2;
  logic          s2_pol;
  logic [CW-1:0] cnt;

  assign s2_pol = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Chain reloads the raw inactive level so no edge is seen after reset.
      s1    <= ACTIVE_LOW;
      s2    <= ACTIVE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2_pol == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        level <= s2_pol;
        cnt   <= '0;
        rise  <= s2_pol;
        fall  <= ~s2_pol;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_sw_conditioner.sv
// Synchronises and debounces raw board keys/switches into clean active-high
// levels, plus one-cycle press/release pulses per key.
module key_sw_conditioner
  import key_sw_conditioner_pkg::*;
#(
  parameter int unsigned CNT_MAX        = DEBOUNCE_CNT_BOARD,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter bit          SW_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] key_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_KEY-1:0] key,
  output logic [N_SW-1:0]  sw,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release
);

  logic [N_SW-1:0] sw_rise_unused;
  logic [N_SW-1:0] sw_fall_unused;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .CNT_MAX    (CNT_MAX),
      .ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (key_raw[i]),
      .level (key[i]),
      .rise  (key_press[i]),
      .fall  (key_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .CNT_MAX    (CNT_MAX),
      .ACTIVE_LOW (SW_ACTIVE_LOW)
    ) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_raw[i]),
      .level (sw[i]),
      .rise  (sw_rise_unused[i]),
      .fall  (sw_fall_unused[i])
    );
  end

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed self-checking bench for key_sw_conditioner with an 8-cycle debounce.
module tb_key_sw_conditioner;
  import key_sw_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_raw;
  logic [3:0] sw_raw;
  logic [3:0] key;
  logic [3:0] sw;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int unsigned checks = 0;
  int unsigned errors = 0;

  key_sw_conditioner #(
    .CNT_MAX        (DEBOUNCE_CNT_SIM),
    .KEY_ACTIVE_LOW (1'b1),
    .SW_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .sw_raw      (sw_raw),
    .key         (key),
    .sw          (sw),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key_raw = 4'b1111;
    sw_raw  = 4'b0000;
    rst_n   = 1'b0;
    repeat (3) tick();
    checks++;
    if ({key, sw, key_press, key_release} !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold key=%b sw=%b press=%b rel=%b expected all 0",
               key, sw, key_press, key_release);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({key, sw, key_press, key_release} !== 16'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d key=%b sw=%b press=%b rel=%b expected all 0",
                 i, key, sw, key_press, key_release);
      end
    end
  endtask

  task automatic test_clean_press();
    key_raw = 4'b1110;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (key !== ((i >= 10) ? 4'b0001 : 4'b0000) ||
          key_press !== ((i == 10) ? 4'b0001 : 4'b0000) ||
          key_release !== 4'b0000) begin
        errors++;
        $display("FAIL clean_press cyc=%0d key=%b press=%b rel=%b expected key=%b press=%b rel=0000",
                 i, key, key_press, key_release,
                 (i >= 10) ? 4'b0001 : 4'b0000, (i == 10) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_bounce();
    for (int seg = 0; seg < 10; seg++) begin
      key_raw[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) begin
        tick();
        checks++;
        if (key !== 4'b0001 || key_press !== 4'b0000) begin
          errors++;
          $display("FAIL bounce_hold seg=%0d key=%b press=%b expected key=0001 press=0000",
                   seg, key, key_press);
        end
      end
    end
    key_raw[1] = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (key !== ((i >= 10) ? 4'b0011 : 4'b0001) ||
          key_press !== ((i == 10) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_settle cyc=%0d key=%b press=%b expected key=%b press=%b",
                 i, key, key_press,
                 (i >= 10) ? 4'b0011 : 4'b0001, (i == 10) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_idle();
    key_raw = 4'b1111;
    sw_raw  = 4'b0000;
    repeat (12) tick();
    checks++;
    if (key !== 4'b0000 || sw !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
      errors++;
      $display("FAIL idle key=%b sw=%b press=%b rel=%b expected all 0",
               key, sw, key_press, key_release);
    end
  endtask

  // A 7-cycle glitch is one short of the acceptance window.
  task automatic test_glitch_boundary();
    key_raw[3] = 1'b0;
    repeat (7) tick();
    key_raw[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (key !== 4'b0000 || key_press !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_7 cyc=%0d key=%b press=%b expected key=0000 press=0000",
                 i, key, key_press);
      end
    end
  endtask

  task automatic test_simultaneous();
    sw_raw  = 4'b0101;
    key_raw = 4'b0101;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (key !== ((i >= 10) ? 4'b1010 : 4'b0000) ||
          sw !== ((i >= 10) ? 4'b0101 : 4'b0000) ||
          key_press !== ((i == 10) ? 4'b1010 : 4'b0000) ||
          key_release !== 4'b0000) begin
        errors++;
        $display("FAIL simultaneous cyc=%0d key=%b sw=%b press=%b rel=%b expected key=%b sw=%b press=%b rel=0000",
                 i, key, sw, key_press, key_release,
                 (i >= 10) ? 4'b1010 : 4'b0000, (i >= 10) ? 4'b0101 : 4'b0000,
                 (i == 10) ? 4'b1010 : 4'b0000);
      end
    end
  endtask

  task automatic test_release();
    key_raw = 4'b1111;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (key !== ((i >= 10) ? 4'b0000 : 4'b1010) ||
          key_release !== ((i == 10) ? 4'b1010 : 4'b0000) ||
          key_press !== 4'b0000 || sw !== 4'b0101) begin
        errors++;
        $display("FAIL release cyc=%0d key=%b rel=%b press=%b sw=%b expected key=%b rel=%b press=0000 sw=0101",
                 i, key, key_release, key_press, sw,
                 (i >= 10) ? 4'b0000 : 4'b1010, (i == 10) ? 4'b1010 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    sw_raw  = 4'b0000;
    key_raw = 4'b1011;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({key, sw, key_press, key_release} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_edge key=%b sw=%b press=%b rel=%b expected all 0",
               key, sw, key_press, key_release);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (key !== ((i >= 10) ? 4'b0100 : 4'b0000) ||
          key_press !== ((i == 10) ? 4'b0100 : 4'b0000) ||
          key_release !== 4'b0000) begin
        errors++;
        $display("FAIL mid_reset_recount cyc=%0d key=%b press=%b rel=%b expected key=%b press=%b rel=0000",
                 i, key, key_press, key_release,
                 (i >= 10) ? 4'b0100 : 4'b0000, (i == 10) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'b1111;
    sw_raw  = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_idle();
    test_glitch_boundary();
    test_simultaneous();
    test_release();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
